prec_scalable_mac_pipe: RTL and testbench
=========================================

Name: prec_scalable_mac_pipe

Overview:
Pipelined, precision-scalable multiply-accumulate engine. It is the parametrised successor of the team's fixed 8x8 MAC unit.
- Computes a dot product of a fixed length over a valid/ready input stream.
- Weight precision is selectable: one full-width product, 2 half-width lanes, or 4 quarter-width lanes.
- The accumulator is partitioned into matching lanes.
- The result is presented on a valid/ready output port. It sits between the operand fetch buffers and the output writeback in the accelerator datapath.

Parameters:
ACT_W, 8, signed activation width.
WGT_W, 8, weight width; must be divisible by 4; slice width S = WGT_W/4.
ACC_W, 56, accumulator width; must be divisible by 4; LANE_W = ACC_W/4.
LEN_W, 16, width of the dot-product length field.

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin a job; honoured only in IDLE.
cfg_prec  in  2  00 full, 01 two half-width weights, 10 four quarter-width weights, 11 reserved.
cfg_len  in  LEN_W  number of input beats in the job.
busy  out  1  high whenever state != IDLE.
cfg_err  out  1  one-cycle pulse when start is given with cfg_prec=11.
in_valid  in  1  operand beat valid.
in_ready  out  1  engine accepts a beat.
in_act  in  ACT_W  signed activation.
in_wgt  in  WGT_W  packed weight(s).
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_acc  out  ACC_W  packed lane results.
out_prec  out  2  precision latched for this result.

Behaviour:
- Reset (async, rstn=0): state IDLE; busy=0, cfg_err=0, in_ready=0, out_valid=0, out_acc=0, out_prec=0; beat counter, pipeline register and accumulator cleared. Reset in any state aborts the job; no partial result is emitted.
- IDLE, start=1, cfg_prec!=11:
  - Latch prec and len; clear the accumulator.
  - Go to ACCUM, or to DONE with out_acc=0 if len==0.
- IDLE, start=1, cfg_prec=11: pulse cfg_err; stay in IDLE.
- start outside IDLE is ignored.
- ACCUM:
  - in_ready=1 while accepted beats < len.
  - A beat fires when in_valid && in_ready; each fire increments the counter.
  - After the len-th fire, in_ready drops the next cycle; go to FLUSH.
- Pipeline:
  - Stage 1 registers the products of a fired beat (one cycle).
  - Stage 2 adds the registered products into the accumulator on the following cycle.
  - Fire-to-accumulate latency is 2 cycles. Throughput is 1 beat per cycle; back-to-back fires are required to work.
- FLUSH: wait one cycle for stage 2 to retire the last beat; go to DONE.
- DONE:
  - out_valid=1; out_acc and out_prec hold stable until out_valid && out_ready.
  - Then out_valid=0 and return to IDLE next cycle.
  - A start in the handshake cycle is ignored.
- Product formation, slice k = in_wgt[(k+1)*S-1 : k*S]:
  - prec 00: in_wgt is signed WGT_W; product is signed ACT_W+WGT_W, sign-extended to ACC_W; one lane of width ACC_W.
  - prec 01: two signed 2S-bit weights (upper and lower halves); products are signed ACT_W+2S; two lanes of 2*LANE_W; lane 0 = lower half.
  - prec 10: four signed S-bit weights; products are signed ACT_W+S; four lanes of LANE_W; lane k = slice k.
- Accumulator implementation:
  - Four LANE_W adder segments with carries chained per prec: 00 all chained, 01 chain 0->1 and 2->3, 10 none.
  - Each lane wraps modulo 2^(lane width); no carry crosses a lane boundary.
- out_acc packing: lane k occupies bits [(k+1)*LW-1 : k*LW], where LW is the lane width for the mode.

Optional Feature:
MAC_SAT_EN
- Defined: each lane saturates to its signed min/max on overflow in stage 2 and stays clamped unless later beats bring it back in range. Overflow is detected as operand signs equal and sum sign different, per lane.
- Undefined: lanes wrap (two's complement).

Decomposition:
- Package prec_mac_pkg:
  - prec_e enum (PREC_FULL=2'b00, PREC_HALF=2'b01, PREC_QTR=2'b10, PREC_RSVD=2'b11).
  - state_e enum (IDLE, ACCUM, FLUSH, DONE).
  - Functions computing lane width and carry-chain mask per prec.
- Sub-module mac_slice_mult: signed ACT_W by packed WGT_W with prec input; combinational; outputs four lane-aligned products, already sign-extended to lane widths for the current mode.

Test Plan:
- Full-precision job: prec=00, len=3, act=-3, wgt=5 each beat -> one out_valid; out_acc = -45 = 56'hFFFFFFFFFFFFD3; out_prec=00.
- Half-precision job: prec=01, len=2, act=2, wgt=8'h7F -> upper lane 28'd28, lower lane 28'hFFFFFFC (-4).
- Quarter-precision job: prec=10, len=4, act=1, wgt=8'b01_10_11_00 -> lanes 3..0 = 14'h0004, 14'h3FF8, 14'h3FFC, 14'h0000.
- Wrap vs saturate: prec=10, act=127, slice0=-2, other slices 0, len=33:
  - Without MAC_SAT_EN, lane0 = 8002.
  - With MAC_SAT_EN, lane0 = -8192 (14'h2000); other lanes 0.
- Backpressure and gaps: in_valid toggling randomly, out_ready low for 5 cycles in DONE -> result equals the gap-free run; out_acc stable while stalled; start pulsed in DONE is ignored.
- Corner cases, each checked separately:
  - start with prec=11 -> cfg_err pulse, busy stays 0.
  - len=0 -> out_acc=0 two cycles after start.
  - rstn low mid-ACCUM -> all outputs 0 and no out_valid afterwards.

Source files
------------

// File: rtl/prec_mac_pkg.sv
// Shared types and helpers for the precision-scalable MAC pipeline.
// Lanes are built from four equal accumulator segments; the helpers below say
// how those segments are grouped for each precision mode.
package prec_mac_pkg;

    typedef enum logic [1:0] {
        PREC_FULL = 2'b00,
        PREC_HALF = 2'b01,
        PREC_QTR  = 2'b10,
        PREC_RSVD = 2'b11
    } prec_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH,
        DONE
    } state_e;

    localparam int unsigned NUM_SEG = 4;

    // Width of one result lane for a given mode and accumulator width.
    function automatic int unsigned lane_width(prec_e prec, int unsigned acc_w);
        int unsigned w;
        unique case (prec)
            PREC_FULL: w = acc_w;
            PREC_HALF: w = acc_w / 2;
            PREC_QTR:  w = acc_w / 4;
            default:   w = 0;
        endcase
        return w;
    endfunction

    // Bit k set: segment k takes the carry out of segment k-1.
    function automatic logic [NUM_SEG-1:0] carry_in_mask(prec_e prec);
        logic [NUM_SEG-1:0] m;
        unique case (prec)
            PREC_FULL: m = 4'b1110;
            PREC_HALF: m = 4'b1010;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

    // Bit k set: segment k holds the sign bit of its lane.
    function automatic logic [NUM_SEG-1:0] lane_end_mask(prec_e prec);
        logic [NUM_SEG-1:0] m;
        unique case (prec)
            PREC_FULL: m = 4'b1000;
            PREC_HALF: m = 4'b1010;
            default:   m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/prec_scalable_mac_pipe_if.sv
// Control, operand-stream and result-stream signals of the MAC engine.
// master = upstream/consumer side, slave = the engine.
interface prec_scalable_mac_pipe_if #(
    parameter int unsigned ACT_W = 8,
    parameter int unsigned WGT_W = 8,
    parameter int unsigned ACC_W = 56,
    parameter int unsigned LEN_W = 16
);
    logic             start;
    logic [1:0]       cfg_prec;
    logic [LEN_W-1:0] cfg_len;
    logic             busy;
    logic             cfg_err;

    logic             in_valid;
    logic             in_ready;
    logic [ACT_W-1:0] in_act;
    logic [WGT_W-1:0] in_wgt;

    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [1:0]       out_prec;

    modport master (
        output start, cfg_prec, cfg_len, in_valid, in_act, in_wgt, out_ready,
        input  busy, cfg_err, in_ready, out_valid, out_acc, out_prec
    );

    modport slave (
        input  start, cfg_prec, cfg_len, in_valid, in_act, in_wgt, out_ready,
        output busy, cfg_err, in_ready, out_valid, out_acc, out_prec
    );

endinterface

// File: rtl/mac_slice_mult.sv
// Combinational precision-scalable multiplier. Produces the product(s) of a
// signed activation with one, two or four signed weight slices, each already
// sign-extended and placed at its lane position inside an ACC_W-wide vector.
module mac_slice_mult
    import prec_mac_pkg::*;
#(
    parameter int unsigned ACT_W = 8,
    parameter int unsigned WGT_W = 8,
    parameter int unsigned ACC_W = 56
) (
    input  logic [ACT_W-1:0] act_i,
    input  logic [WGT_W-1:0] wgt_i,
    input  prec_e            prec_i,
    output logic [ACC_W-1:0] prod_o
);

    localparam int unsigned S       = WGT_W / 4;
    localparam int unsigned LANE_W  = ACC_W / 4;
    localparam int unsigned HLANE_W = 2 * LANE_W;
    localparam int unsigned FULL_W  = ACT_W + WGT_W;
    localparam int unsigned HALF_W  = ACT_W + 2 * S;
    localparam int unsigned QTR_W   = ACT_W + S;

    logic signed [FULL_W-1:0] p_full;
    logic signed [HALF_W-1:0] p_half [2];
    logic signed [QTR_W-1:0]  p_qtr  [4];

    // Form all candidate products, then place the ones for the active mode.
    always_comb begin
        p_full = FULL_W'($signed(act_i)) * FULL_W'($signed(wgt_i));
        for (int k = 0; k < 2; k++) begin
            p_half[k] = HALF_W'($signed(act_i)) * HALF_W'($signed(wgt_i[k*2*S +: 2*S]));
        end
        for (int k = 0; k < 4; k++) begin
            p_qtr[k] = QTR_W'($signed(act_i)) * QTR_W'($signed(wgt_i[k*S +: S]));
        end

        prod_o = '0;
        unique case (prec_i)
            PREC_FULL: prod_o = ACC_W'(p_full);
            PREC_HALF: begin
                for (int k = 0; k < 2; k++) begin
                    prod_o[k*HLANE_W +: HLANE_W] = HLANE_W'(p_half[k]);
                end
            end
            PREC_QTR: begin
                for (int k = 0; k < 4; k++) begin
                    prod_o[k*LANE_W +: LANE_W] = LANE_W'(p_qtr[k]);
                end
            end
            default: prod_o = '0;
        endcase
    end

endmodule

// File: rtl/prec_scalable_mac_pipe.sv
// Pipelined precision-scalable dot-product engine.
// Stage 1 registers the products of an accepted beat, stage 2 adds them into a
// four-segment accumulator whose carry chain is cut at lane boundaries.
// Build option MAC_SAT_EN: lanes saturate to their signed limits instead of
// wrapping.
module prec_scalable_mac_pipe
    import prec_mac_pkg::*;
#(
    parameter int unsigned ACT_W = 8,
    parameter int unsigned WGT_W = 8,
    parameter int unsigned ACC_W = 56,
    parameter int unsigned LEN_W = 16
) (
    input logic                     clk,
    input logic                     rstn,
    prec_scalable_mac_pipe_if.slave bus
);

    localparam int unsigned LANE_W = ACC_W / 4;

    state_e                 state_q, state_d;
    prec_e                  prec_q, prec_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   fire;
    logic                   acc_clr;

    logic [ACC_W-1:0]       mult_prod;
    logic [ACC_W-1:0]       prod_q, prod_d;
    logic                   prod_vld_q, prod_vld_d;
    logic [ACC_W-1:0]       acc_q, acc_d;

    logic [3:0][LANE_W-1:0] acc_seg, prod_seg, sum_seg, acc_sum;
    logic [3:0]             cin_mask;
    logic                   carry, cin;

    mac_slice_mult #(
        .ACT_W (ACT_W),
        .WGT_W (WGT_W),
        .ACC_W (ACC_W)
    ) u_mult (
        .act_i  (bus.in_act),
        .wgt_i  (bus.in_wgt),
        .prec_i (prec_q),
        .prod_o (mult_prod)
    );

    assign fire = bus.in_valid && in_ready_q;

    // Job sequencing: next state, beat counting and registered status outputs.
    always_comb begin
        state_d     = state_q;
        prec_d      = prec_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        cfg_err_d   = 1'b0;
        acc_clr     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (prec_e'(bus.cfg_prec) == PREC_RSVD) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        prec_d  = prec_e'(bus.cfg_prec);
                        len_d   = bus.cfg_len;
                        cnt_d   = '0;
                        acc_clr = 1'b1;
                        if (bus.cfg_len == '0) begin
                            state_d     = DONE;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
            end
            ACCUM: begin
                if (fire) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Last beat retires from stage 2 on this edge.
                state_d     = DONE;
                out_valid_d = 1'b1;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == ACCUM) && (cnt_d < len_d);
        busy_d     = (state_d != IDLE);
    end

    // Stage 1 capture and stage 2 segmented add with per-mode carry cuts.
    always_comb begin
        prod_d     = fire ? mult_prod : prod_q;
        prod_vld_d = fire;

        acc_seg  = acc_q;
        prod_seg = prod_q;
        cin_mask = carry_in_mask(prec_q);
        sum_seg  = '0;
        carry    = 1'b0;
        cin      = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cin = cin_mask[k] & carry;
            {carry, sum_seg[k]} = {1'b0, acc_seg[k]} + {1'b0, prod_seg[k]}
                                + {{LANE_W{1'b0}}, cin};
        end
    end

`ifdef MAC_SAT_EN
    logic [3:0] end_mask;
    logic       lane_ovf, lane_neg;

    // Clamp each lane whose add overflowed; walk from the top so every segment
    // sees the overflow verdict of the lane it belongs to.
    always_comb begin
        end_mask = lane_end_mask(prec_q);
        lane_ovf = 1'b0;
        lane_neg = 1'b0;
        acc_sum  = '0;
        for (int j = 3; j >= 0; j--) begin
            if (end_mask[j]) begin
                lane_neg = acc_seg[j][LANE_W-1];
                lane_ovf = (acc_seg[j][LANE_W-1] == prod_seg[j][LANE_W-1])
                        && (sum_seg[j][LANE_W-1] != acc_seg[j][LANE_W-1]);
            end
            if (!lane_ovf) begin
                acc_sum[j] = sum_seg[j];
            end else if (end_mask[j]) begin
                acc_sum[j] = lane_neg ? {1'b1, {(LANE_W-1){1'b0}}}
                                      : {1'b0, {(LANE_W-1){1'b1}}};
            end else begin
                acc_sum[j] = lane_neg ? '0 : '1;
            end
        end
    end
`else
    assign acc_sum = sum_seg;
`endif

    // Accumulator update: clear on job start, add when stage 1 holds a beat.
    always_comb begin
        if (acc_clr) begin
            acc_d = '0;
        end else if (prod_vld_q) begin
            acc_d = acc_sum;
        end else begin
            acc_d = acc_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            prec_q      <= PREC_FULL;
            len_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prec_q      <= prec_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Datapath registers: product pipeline and accumulator.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = acc_q;
    assign bus.out_prec  = prec_q;

endmodule

// File: tb/tb_prec_scalable_mac_pipe.sv
// Self-checking bench for prec_scalable_mac_pipe: directed jobs from the
// design's worked examples plus randomized jobs against a lane-sum model.
module tb_prec_scalable_mac_pipe;

    logic clk;
    logic rstn;

    prec_scalable_mac_pipe_if bus ();

    prec_scalable_mac_pipe dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks;
    int failures;

    logic [7:0] act_mem [64];
    logic [7:0] wgt_mem [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact per-lane integer sums, then wrapped (or clamped per beat).
    function automatic logic [55:0] model_job(input logic [1:0] prec, input int len);
        int          nl, lw, sw, raw;
        longint      lane [4];
        longint      a, lim;
        logic [55:0] r;
        nl  = (prec == 2'b00) ? 1 : (prec == 2'b01) ? 2 : 4;
        lw  = 56 / nl;
        sw  = 8 / nl;
        lim = longint'(1) << (lw - 1);
        for (int k = 0; k < 4; k++) lane[k] = 0;
        for (int b = 0; b < len; b++) begin
            a = longint'($signed(act_mem[b]));
            for (int k = 0; k < nl; k++) begin
                raw = int'(wgt_mem[b]) >> (k * sw);
                raw = raw & ((1 << sw) - 1);
                if (raw >= (1 << (sw - 1))) raw = raw - (1 << sw);
                lane[k] = lane[k] + a * longint'(raw);
`ifdef MAC_SAT_EN
                if (lane[k] > lim - 1) lane[k] = lim - 1;
                if (lane[k] < -lim) lane[k] = -lim;
`endif
            end
        end
        r = '0;
        for (int k = 0; k < nl; k++) begin
            r = r | ((56'(lane[k]) & ((56'd1 << lw) - 56'd1)) << (k * lw));
        end
        return r;
    endfunction

    // Drives one job and reports what was observed; callers do the comparing.
    task automatic run_job(input logic [1:0] prec, input int len, input int gap,
                           input int stall, output logic [55:0] acc,
                           output logic [1:0] oprec, output int beats, output int cycles,
                           output bit tmo, output bit stable, output bit idle_after);
        bit got, fire;
        bus.cfg_prec = prec;
        bus.cfg_len  = 16'(len);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        beats  = 0;
        cycles = 0;
        got    = 1'b0;
        stable = 1'b1;
        while (!got && cycles < 3000) begin
            if (bus.out_valid) begin
                got = 1'b1;
            end else begin
                bus.in_valid = (beats < len) && (int'($urandom_range(0, 99)) >= gap);
                if (beats < len) begin
                    bus.in_act = act_mem[beats];
                    bus.in_wgt = wgt_mem[beats];
                end
                fire = bus.in_valid && bus.in_ready;
                @(posedge clk); #1;
                if (fire) beats++;
                cycles++;
            end
        end
        bus.in_valid = 1'b0;
        tmo   = !got;
        acc   = bus.out_acc;
        oprec = bus.out_prec;
        // Hold the result; a start pulse here must not disturb it.
        for (int s = 0; s < stall; s++) begin
            bus.start    = (s == 0);
            bus.cfg_prec = 2'b00;
            bus.cfg_len  = 16'd5;
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (!bus.out_valid || bus.out_acc !== acc || bus.in_ready) stable = 1'b0;
        end
        // Handshake cycle, with another start that must be ignored.
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.cfg_prec  = 2'b10;
        bus.cfg_len   = 16'd3;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        idle_after = !bus.out_valid && !bus.busy;
        @(posedge clk); #1;
        idle_after = idle_after && !bus.busy && !bus.out_valid;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.busy, bus.cfg_err, bus.in_ready, bus.out_valid} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags: busy/cfg_err/in_ready/out_valid=%b want 0000",
                     {bus.busy, bus.cfg_err, bus.in_ready, bus.out_valid});
        end
        checks++;
        if (bus.out_acc !== 56'h0 || bus.out_prec !== 2'b00) begin
            failures++;
            $display("FAIL reset_data: out_acc=%h out_prec=%b want 0/00", bus.out_acc,
                     bus.out_prec);
        end
    endtask

    task automatic test_full();
        logic [55:0] acc; logic [1:0] p; int beats, cyc; bit tmo, st, idl;
        for (int i = 0; i < 3; i++) begin act_mem[i] = 8'hFD; wgt_mem[i] = 8'd5; end
        run_job(2'b00, 3, 0, 0, acc, p, beats, cyc, tmo, st, idl);
        checks++;
        if (acc !== 56'hFFFFFFFFFFFFD3) begin
            failures++; $display("FAIL full_acc: got %h want %h", acc, 56'hFFFFFFFFFFFFD3);
        end
        checks++;
        if (p !== 2'b00) begin failures++; $display("FAIL full_prec: got %b want 00", p); end
        checks++;
        if (cyc !== 4 || tmo) begin
            failures++; $display("FAIL full_latency: got %0d cycles (tmo=%0d) want 4", cyc, tmo);
        end
        checks++;
        if (!idl) begin failures++; $display("FAIL full_idle: got busy after handshake"); end
    endtask

    task automatic test_half();
        logic [55:0] acc; logic [1:0] p; int beats, cyc; bit tmo, st, idl;
        for (int i = 0; i < 2; i++) begin act_mem[i] = 8'd2; wgt_mem[i] = 8'h7F; end
        run_job(2'b01, 2, 0, 0, acc, p, beats, cyc, tmo, st, idl);
        checks++;
        if (acc !== {28'd28, 28'hFFFFFFC}) begin
            failures++; $display("FAIL half_acc: got %h want %h", acc, {28'd28, 28'hFFFFFFC});
        end
        checks++;
        if (p !== 2'b01 || beats !== 2) begin
            failures++; $display("FAIL half_prec: got prec %b beats %0d want 01/2", p, beats);
        end
    endtask

    task automatic test_qtr();
        logic [55:0] acc; logic [1:0] p; int beats, cyc; bit tmo, st, idl;
        for (int i = 0; i < 4; i++) begin act_mem[i] = 8'd1; wgt_mem[i] = 8'b01_10_11_00; end
        run_job(2'b10, 4, 0, 0, acc, p, beats, cyc, tmo, st, idl);
        checks++;
        if (acc !== {14'h0004, 14'h3FF8, 14'h3FFC, 14'h0000}) begin
            failures++;
            $display("FAIL qtr_acc: got %h want %h", acc,
                     {14'h0004, 14'h3FF8, 14'h3FFC, 14'h0000});
        end
        checks++;
        if (cyc !== 5) begin failures++; $display("FAIL qtr_latency: got %0d want 5", cyc); end
    endtask

    task automatic test_len_zero();
        logic [55:0] acc; logic [1:0] p; int beats, cyc; bit tmo, st, idl;
        run_job(2'b01, 0, 0, 2, acc, p, beats, cyc, tmo, st, idl);
        checks++;
        if (acc !== 56'h0 || tmo) begin
            failures++; $display("FAIL len0_acc: got %h (tmo=%0d) want 0", acc, tmo);
        end
        checks++;
        if (!st || beats !== 0 || p !== 2'b01) begin
            failures++;
            $display("FAIL len0_hold: stable=%0d beats=%0d prec=%b want 1/0/01", st, beats, p);
        end
    endtask

    task automatic test_cfg_err();
        bus.cfg_prec = 2'b11;
        bus.cfg_len  = 16'd4;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL cfg_err_pulse: cfg_err=%b busy=%b want 1/0", bus.cfg_err, bus.busy);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.cfg_err !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL cfg_err_after: cfg_err=%b busy=%b in_ready=%b want 0/0/0",
                     bus.cfg_err, bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_wrap_sat();
        logic [55:0] acc, want; logic [1:0] p; int beats, cyc; bit tmo, st, idl;
        for (int i = 0; i < 33; i++) begin act_mem[i] = 8'd127; wgt_mem[i] = 8'b00_00_00_10; end
`ifdef MAC_SAT_EN
        want = {42'h0, 14'h2000};
`else
        want = {42'h0, 14'd8002};
`endif
        run_job(2'b10, 33, 0, 0, acc, p, beats, cyc, tmo, st, idl);
        checks++;
        if (acc !== want) begin
            failures++; $display("FAIL wrap_sat_acc: got %h want %h", acc, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [55:0] acc, want; logic [1:0] p, prec; int len, beats, cyc; bit tmo, st, idl;
        for (int j = 0; j < 4; j++) begin
            prec = 2'($urandom_range(0, 2));
            len  = int'($urandom_range(1, 40));
            for (int i = 0; i < len; i++) begin
                act_mem[i] = 8'($urandom); wgt_mem[i] = 8'($urandom);
            end
            want = model_job(prec, len);
            run_job(prec, len, 0, 0, acc, p, beats, cyc, tmo, st, idl);
            checks++;
            if (acc !== want) begin
                failures++;
                $display("FAIL b2b_acc[%0d]: prec %b len %0d got %h want %h", j, prec, len,
                         acc, want);
            end
            checks++;
            if (cyc !== len + 1 || beats !== len) begin
                failures++;
                $display("FAIL b2b_timing[%0d]: cycles %0d beats %0d want %0d/%0d", j, cyc,
                         beats, len + 1, len);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [55:0] acc, want; logic [1:0] p, prec; int len, beats, cyc; bit tmo, st, idl;
        for (int j = 0; j < 5; j++) begin
            prec = 2'($urandom_range(0, 2));
            len  = int'($urandom_range(1, 30));
            for (int i = 0; i < len; i++) begin
                act_mem[i] = 8'($urandom); wgt_mem[i] = 8'($urandom);
            end
            want = model_job(prec, len);
            run_job(prec, len, int'($urandom_range(20, 70)), 5, acc, p, beats, cyc, tmo, st,
                    idl);
            checks++;
            if (acc !== want || tmo) begin
                failures++;
                $display("FAIL bp_acc[%0d]: prec %b len %0d got %h want %h tmo %0d", j, prec,
                         len, acc, want, tmo);
            end
            checks++;
            if (p !== prec || beats !== len) begin
                failures++;
                $display("FAIL bp_prec_beats[%0d]: prec %b beats %0d want %b/%0d", j, p, beats,
                         prec, len);
            end
            checks++;
            if (!st || !idl) begin
                failures++;
                $display("FAIL bp_hold[%0d]: stable %0d idle_after %0d want 1/1", j, st, idl);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        for (int i = 0; i < 10; i++) begin
            act_mem[i] = 8'($urandom); wgt_mem[i] = 8'($urandom);
        end
        bus.cfg_prec = 2'b10;
        bus.cfg_len  = 16'd10;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_act = act_mem[i];
            bus.in_wgt = wgt_mem[i];
            @(posedge clk); #1;
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL mid_busy: got %b want 1", bus.busy);
        end
        #2;
        rstn         = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.cfg_err, bus.in_ready, bus.out_valid, bus.out_prec, bus.out_acc}
            !== 62'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs: busy %b in_ready %b out_valid %b prec %b acc %h",
                     bus.busy, bus.in_ready, bus.out_valid, bus.out_prec, bus.out_acc);
        end
        @(posedge clk); #3;
        rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid || bus.busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL mid_no_result: activity seen %b want 0", seen);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rstn          = 1'b0;
        bus.start     = 1'b0;
        bus.cfg_prec  = 2'b00;
        bus.cfg_len   = '0;
        bus.in_valid  = 1'b0;
        bus.in_act    = '0;
        bus.in_wgt    = '0;
        bus.out_ready = 1'b0;
        #22;
        rstn = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_full();
        test_half();
        test_qtr();
        test_len_zero();
        test_cfg_err();
        test_wrap_sat();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
